// File: rtl/pipeline_step_controller_pkg.sv
// Shared types for the run/halt/single-step pipeline sequencer.
// State encoding and control bundle are private to this block.
package pipeline_step_controller_pkg;

    localparam int RISCV_XLEN = 32;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } step_state_t;

    typedef struct packed {
        logic pipe_enable;
        logic set_bp_hit;
        logic clr_bp_hit;
        logic set_skip;
        logic clr_skip;
    } step_ctl_t;

    localparam step_ctl_t CTL_IDLE = '0;

endpackage

// File: rtl/pipeline_step_controller_key_debouncer.sv
// Board key conditioner: 2-flop synchroniser, stability counter and
// a one-cycle press pulse on each accepted 1->0 level change.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          key_meta;
    logic          key_sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            key_meta  <= 1'b1;
            key_sync  <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            key_meta  <= key_n;
            key_sync  <= key_meta;
            press_evt <= 1'b0;
            if (key_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Level accepted; only a falling level is a press.
                level     <= key_sync;
                cnt       <= '0;
                press_evt <= ~key_sync;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pipeline_step_controller.sv
// Run/halt/single-step sequencer producing the shared pipe_enable
// strobe from step key, step-mode switch, breakpoint and resume pulse.
module pipeline_step_controller
    import pipeline_step_controller_pkg::*;
#(
    parameter int XLEN            = RISCV_XLEN,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            step_key_n,
    input  logic            mode_step,
    input  logic            bp_enable,
    input  logic [XLEN-1:0] bp_addr,
    input  logic [XLEN-1:0] pc,
    input  logic            run_req,
    output logic            pipe_enable,
    output logic            halted,
    output logic            bp_hit,
    output logic [31:0]     enabled_count
);

    step_state_t state;
    step_state_t state_next;
    step_ctl_t   ctl;

    logic        mode_meta;
    logic        mode_sync;
    logic        bp_en_meta;
    logic        bp_en_sync;
    logic        step_evt;
    logic        key_level_unused;
    logic        skip_bp;
    logic        bp_match;
    logic [31:0] count_q;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_key (
        .clock    (clock),
        .reset    (reset),
        .key_n    (step_key_n),
        .level    (key_level_unused),
        .press_evt(step_evt)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_meta  <= 1'b0;
            mode_sync  <= 1'b0;
            bp_en_meta <= 1'b0;
            bp_en_sync <= 1'b0;
        end else begin
            mode_meta  <= mode_step;
            mode_sync  <= mode_meta;
            bp_en_meta <= bp_enable;
            bp_en_sync <= bp_en_meta;
        end
    end

    // skip_bp lets a resumed run leave the breakpoint PC.
    assign bp_match = bp_en_sync && (pc == bp_addr) && !skip_bp;

    always_comb begin
        state_next = state;
        ctl        = CTL_IDLE;
        unique case (state)
            ST_HALT: begin
                if (run_req) begin
                    state_next     = ST_RUN;
                    ctl.clr_bp_hit = 1'b1;
                    ctl.set_skip   = 1'b1;
                end else if (step_evt) begin
                    state_next = ST_STEP;
                end else if (!mode_sync && !bp_hit) begin
                    state_next   = ST_RUN;
                    ctl.set_skip = 1'b1;
                end
            end
            ST_STEP: begin
                ctl.pipe_enable = 1'b1;
                state_next      = ST_HALT;
            end
            ST_RUN: begin
                if (bp_match) begin
                    ctl.set_bp_hit = 1'b1;
                    state_next     = ST_HALT;
                end else if (mode_sync) begin
                    state_next = ST_HALT;
                end else begin
                    ctl.pipe_enable = 1'b1;
                    ctl.clr_skip    = 1'b1;
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    assign pipe_enable = ctl.pipe_enable & reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_HALT;
            halted  <= 1'b1;
            bp_hit  <= 1'b0;
            skip_bp <= 1'b0;
            count_q <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALT);
            bp_hit <= ctl.set_bp_hit | (bp_hit & ~ctl.clr_bp_hit);
            if (ctl.set_skip) begin
                skip_bp <= 1'b1;
            end else if (ctl.clr_skip) begin
                skip_bp <= 1'b0;
            end
            if (pipe_enable) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign enabled_count = count_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Bench for pipeline_step_controller: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_pipeline_step_controller;

    localparam int D = 4;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        step_key_n;
    logic        mode_step;
    logic        bp_enable;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        run_req;
    logic        pipe_enable;
    logic        halted;
    logic        bp_hit;
    logic [31:0] enabled_count;

    int checks = 0;
    int errors = 0;

    pipeline_step_controller #(
        .XLEN           (32),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .step_key_n   (step_key_n),
        .mode_step    (mode_step),
        .bp_enable    (bp_enable),
        .bp_addr      (bp_addr),
        .pc           (pc),
        .run_req      (run_req),
        .pipe_enable  (pipe_enable),
        .halted       (halted),
        .bp_hit       (bp_hit),
        .enabled_count(enabled_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic mode);
        @(negedge clock);
        reset      = 1'b0;
        step_key_n = 1'b1;
        mode_step  = mode;
        run_req    = 1'b0;
        @(negedge clock);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        bit          mode;
        bit          key;
        bit          run;
        bit          pe;
        bit          hlt;
        int unsigned cnt;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input bit r, input bit m, input bit k, input bit rr,
                                input bit p, input bit h, input int unsigned c);
        vec_t v;
        v.rst = r; v.mode = m; v.key = k; v.run = rr;
        v.pe = p; v.hlt = h; v.cnt = c;
        tv.push_back(v);
    endfunction

    // ---------------- behavioural model ----------------
    bit [31:0] m_cnt;
    int        m_st;
    bit        m_hit, m_skip, m_evt, m_lvl;
    bit        kq[$], mq[$], bq[$], hq[$];

    function automatic void model_reset();
        m_cnt = 0; m_st = M_HALT;
        m_hit = 0; m_skip = 0; m_evt = 0; m_lvl = 1;
        kq = {1'b1, 1'b1};
        mq = {1'b0, 1'b0};
        bq = {1'b0, 1'b0};
        hq.delete();
    endfunction

    initial begin
        bit          pe_last, found, h, pe_e, match, all_diff, flip;
        bit          key_s, mode_s, be_s;
        logic [31:0] w;
        logic [31:0] mpc;

        reset = 1'b0; step_key_n = 1'b1; mode_step = 1'b0;
        bp_enable = 1'b0; bp_addr = 32'h10; pc = 32'h0; run_req = 1'b0;

        // Reset/free-run start, stop via mode switch, one step, glitch.
        add(0,0,1,0, 0,1,0);
        add(1,0,1,0, 0,1,0);
        for (int k = 0; k < 3; k++) add(1,0,1,0, 1,0,k);
        add(1,1,1,0, 1,0,3);
        add(1,1,1,0, 1,0,4);
        add(1,1,1,0, 0,0,5);
        add(1,1,1,0, 0,1,5);
        for (int k = 0; k < 7; k++) add(1,1,0,0, 0,1,5);
        add(1,1,0,0, 1,0,5);
        for (int k = 0; k < 12; k++) add(1,1,0,0, 0,1,6);
        for (int k = 0; k < 12; k++) add(1,1,1,0, 0,1,6);
        for (int k = 0; k < 3; k++)  add(1,1,0,0, 0,1,6);
        for (int k = 0; k < 12; k++) add(1,1,1,0, 0,1,6);

        do_reset(1'b0);
        foreach (tv[i]) begin
            @(negedge clock);
            reset = tv[i].rst; mode_step = tv[i].mode;
            step_key_n = tv[i].key; run_req = tv[i].run;
            #2;
            chk1($sformatf("tbl%0d_pe", i), pipe_enable, tv[i].pe);
            chk1($sformatf("tbl%0d_halted", i), halted, tv[i].hlt);
            chk1($sformatf("tbl%0d_bp_hit", i), bp_hit, 1'b0);
            chk32($sformatf("tbl%0d_count", i), enabled_count, tv[i].cnt);
        end

        // Breakpoint: zero-latency stop, sticky flag, resume past it.
        bp_enable = 1'b1; bp_addr = 32'h10; pc = 32'h0;
        do_reset(1'b0);
        pe_last = 0; found = 0;
        for (int g = 0; g < 20 && !found; g++) begin
            @(negedge clock);
            reset = 1'b1;
            if (pe_last) pc = pc + 32'd4;
            #2;
            if (pc == 32'h10) found = 1;
            else pe_last = pipe_enable;
        end
        chk1("bp_reach", found, 1'b1);
        chk1("bp_same_cycle_pe", pipe_enable, 1'b0);
        chk1("bp_same_cycle_state", halted, 1'b0);
        @(negedge clock); #2;
        chk1("bp_halted", halted, 1'b1);
        chk1("bp_hit_set", bp_hit, 1'b1);
        repeat (3) begin
            @(negedge clock); #2;
            chk1("bp_hold_pe", pipe_enable, 1'b0);
        end
        @(negedge clock); run_req = 1'b1; #2;
        chk1("resume_req_pe", pipe_enable, 1'b0);
        @(negedge clock); run_req = 1'b0; #2;
        chk1("resume_pe", pipe_enable, 1'b1);
        chk1("resume_clr_hit", bp_hit, 1'b0);
        @(negedge clock); pc = pc + 32'd4; #2;
        chk1("past_bp_pe", pipe_enable, 1'b1);
        chk1("past_bp_hit", bp_hit, 1'b0);
        bp_enable = 1'b0;

        // run_req and step event together: RUN wins.
        do_reset(1'b1);
        release_reset();
        repeat (6) @(negedge clock);
        for (int k = 0; k < 17; k++) begin
            @(negedge clock);
            step_key_n = 1'b0;
            run_req = (k == 6);
            #2;
            if (k == 6) begin
                chk1("both_halt_pe", pipe_enable, 1'b0);
                chk1("both_halt_state", halted, 1'b1);
            end
            if (k == 7) begin
                chk1("both_run_not_step_pe", pipe_enable, 1'b0);
                chk1("both_run_state", halted, 1'b0);
            end
            if (k >= 8) chk1("no_queued_step", pipe_enable, 1'b0);
            if (k == 8) chk1("both_back_halt", halted, 1'b1);
        end
        run_req = 1'b0;

        // Step event while running is dropped.
        do_reset(1'b0);
        release_reset();
        repeat (3) @(negedge clock);
        for (int k = 0; k < 13; k++) begin
            @(negedge clock);
            step_key_n = 1'b0;
            #2;
            chk1("run_ignores_step", pipe_enable, 1'b1);
        end
        mode_step = 1'b1;
        h = 0;
        for (int g = 0; g < 8 && !h; g++) begin
            @(negedge clock); #2;
            h = halted;
        end
        chk1("halt_reach", h, 1'b1);
        repeat (8) begin
            @(negedge clock); #2;
            chk1("no_late_step", pipe_enable, 1'b0);
        end

        // Reset asserted in the STEP cycle.
        do_reset(1'b0);
        release_reset();
        repeat (5) @(negedge clock);
        mode_step = 1'b1;
        repeat (5) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            step_key_n = 1'b0;
            #2;
            if (k == 7) begin
                chk1("step_pulse", pipe_enable, 1'b1);
                #1 reset = 1'b0;
            end
        end
        @(negedge clock); #2;
        chk1("rst_step_pe", pipe_enable, 1'b0);
        chk1("rst_step_halted", halted, 1'b1);
        chk1("rst_step_bp_hit", bp_hit, 1'b0);
        chk32("rst_step_count", enabled_count, 32'h0);

        // enabled_count wrap while free running.
        do_reset(1'b0);
        release_reset();
        repeat (3) @(negedge clock);
        force dut.count_q = 32'hFFFF_FFFE;
        #1 release dut.count_q;
        #1 chk32("wrap_preload", enabled_count, 32'hFFFF_FFFE);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock); #2;
            w = 32'hFFFF_FFFE + 32'(k);
            chk32($sformatf("wrap_count%0d", k), enabled_count, w);
            chk1("wrap_pe", pipe_enable, 1'b1);
            chk1("wrap_state", halted, 1'b0);
        end

        // Randomized run against the model.
        mode_step = 1'b0; bp_enable = 1'b1; bp_addr = 32'h10;
        mpc = 32'h0; pc = 32'h0;
        do_reset(1'b0);
        model_reset();
        for (int n = 0; n < 2500; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) mode_step = ~mode_step;
            if ($urandom_range(0, 49) == 0) bp_enable = ~bp_enable;
            if ($urandom_range(0, 5) == 0) step_key_n = ~step_key_n;
            run_req = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 15) == 0) mpc = 32'(4 * $urandom_range(0, 15));
            pc = mpc;
            #2;
            key_s = kq[1]; mode_s = mq[1]; be_s = bq[1];
            match = (m_st == M_RUN) && be_s && (pc == bp_addr) && !m_skip;
            pe_e = reset && ((m_st == M_STEP) ||
                             (m_st == M_RUN && !match && !mode_s));
            chk1("rnd_pe", pipe_enable, pe_e);
            chk1("rnd_halted", halted, m_st == M_HALT);
            chk1("rnd_bp_hit", bp_hit, m_hit);
            chk32("rnd_count", enabled_count, m_cnt);
            if (pe_e) mpc = (mpc + 32'd4) & 32'h3C;
            if (!reset) begin
                model_reset();
                mpc = 32'h0;
            end else begin
                if (pe_e) m_cnt = m_cnt + 32'd1;
                case (m_st)
                    M_HALT: begin
                        if (run_req) begin
                            m_st = M_RUN; m_hit = 0; m_skip = 1;
                        end else if (m_evt) begin
                            m_st = M_STEP;
                        end else if (!mode_s && !m_hit) begin
                            m_st = M_RUN; m_skip = 1;
                        end
                    end
                    M_STEP: m_st = M_HALT;
                    default: begin
                        if (match) begin
                            m_hit = 1; m_st = M_HALT;
                        end else if (mode_s) begin
                            m_st = M_HALT;
                        end
                        if (pe_e) m_skip = 0;
                    end
                endcase
                // Accept a level once the last D synced samples all differ.
                hq.push_back(key_s);
                if (hq.size() > D) void'(hq.pop_front());
                all_diff = 1;
                foreach (hq[j]) if (hq[j] == m_lvl) all_diff = 0;
                flip = (hq.size() == D) && all_diff;
                m_evt = flip && (key_s == 1'b0);
                if (flip) m_lvl = key_s;
                kq.push_front(step_key_n); void'(kq.pop_back());
                mq.push_front(mode_step);  void'(mq.pop_back());
                bq.push_front(bp_enable);  void'(bq.pop_back());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
